// File: rtl/arbiter_n_to_1_request_rr.sv
// Round-robin N-to-1 request arbiter feeding an internal circular buffer drained under rd_en.
// Optional per-requestor grant counters are enabled by defining ARBITER_N_TO_1_STATS_EN.

package arbiter_n_to_1_request_rr_pkg;
    localparam int unsigned PAYLOAD_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
    } MemoryPacket;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic full;
        logic empty;
        logic prog_full;
        logic valid;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutput;
endpackage

module arbiter_n_to_1_request_rr
    import arbiter_n_to_1_request_rr_pkg::*;
#(
    parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
    parameter int unsigned FIFO_DEPTH           = 32,
    parameter int unsigned PROG_THRESH          = 16
) (
    input  logic                                  ap_clk,
    input  logic                                  areset,
    input  MemoryPacket [NUM_MEMORY_REQUESTOR-1:0] request_in,
    output logic [NUM_MEMORY_REQUESTOR-1:0]       grant_out,
    input  FIFOStateSignalsInput                  fifo_request_signals_in,
    output FIFOStateSignalsOutput                 fifo_request_signals_out,
    output MemoryPacket                           request_out,
    output logic                                  fifo_setup_signal
`ifdef ARBITER_N_TO_1_STATS_EN
    ,
    output logic [NUM_MEMORY_REQUESTOR-1:0][31:0] grant_count_out
`endif
);
    localparam int unsigned N     = NUM_MEMORY_REQUESTOR;
    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    typedef enum logic [1:0] {StSetup, StIdle, StGrant, StStall} state_e;

    logic                  areset_control;
    state_e                state_q;
    logic                  setup_q;
    logic [PTR_W-1:0]      rr_ptr_q;
    logic [N-1:0]          req_valid;
    logic [2*N-1:0]        req_dbl;
    logic                  found;
    logic [IDX_W-1:0]      sel_off, sel_idx, sel_next;
    logic                  any_valid, grant_fire;
    logic [PAYLOAD_W-1:0]  grant_data;
    logic                  wr_pend_q;
    logic [PAYLOAD_W-1:0]  wr_data_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, occ, occ_next;
    logic [PAYLOAD_W-1:0]  mem [FIFO_DEPTH];
    logic                  rd_en_reg, pop, wr_fire, buf_empty, buf_full;
    logic                  out_valid_q;
    logic [PAYLOAD_W-1:0]  out_payload_q;
    FIFOStateSignalsOutput status_q;

    always_ff @(posedge ap_clk) areset_control <= areset;

    // Rotate valids so the search always starts at the round-robin pointer.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < N; i++) req_valid[i] = request_in[i].valid;
        any_valid = |req_valid;
        req_dbl   = {req_valid, req_valid} >> rr_ptr_q;
        found     = 1'b0;
        sel_off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_dbl[k]) begin
                found   = 1'b1;
                sel_off = IDX_W'(k);
            end
        end
        sel_idx = {1'b0, rr_ptr_q} + sel_off;
        if (sel_idx >= IDX_W'(N)) sel_idx = sel_idx - IDX_W'(N);
        sel_next = sel_idx + IDX_W'(1);
        if (sel_next == IDX_W'(N)) sel_next = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_idx == IDX_W'(i)) grant_data = request_in[i].payload;
        end
    end

    // Occupancy counts the captured-but-unwritten packet so granting stops exactly at threshold.
    always_comb begin
        buf_empty  = (count_q == '0);
        buf_full   = (count_q == CNT_W'(FIFO_DEPTH));
        pop        = rd_en_reg && !buf_empty;
        wr_fire    = wr_pend_q && !buf_full;
        occ        = count_q + CNT_W'(wr_pend_q);
        grant_fire = (state_q == StGrant) && any_valid && (occ < CNT_W'(PROG_THRESH));
        occ_next   = occ + CNT_W'(grant_fire) - CNT_W'(pop);
        grant_out  = grant_fire ? (N'(1) << sel_idx) : '0;
    end

    always_ff @(posedge ap_clk) begin
        if (areset_control) begin
            state_q <= StSetup;
            setup_q <= 1'b1;
        end else begin
            case (state_q)
                StSetup: begin
                    state_q <= StIdle;
                    setup_q <= 1'b0;
                end
                StIdle: if (any_valid && occ < CNT_W'(PROG_THRESH)) state_q <= StGrant;
                StGrant: begin
                    if (occ_next >= CNT_W'(PROG_THRESH)) state_q <= StStall;
                    else if (!any_valid)                  state_q <= StIdle;
                end
                StStall: if (occ < CNT_W'(PROG_THRESH)) state_q <= any_valid ? StGrant : StIdle;
                default: state_q <= StSetup;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset_control) begin
            rr_ptr_q    <= '0;
            wr_pend_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_en_reg   <= 1'b0;
            out_valid_q <= 1'b0;
            status_q    <= '{full: 1'b0, empty: 1'b1, prog_full: 1'b0, valid: 1'b0,
                            wr_rst_busy: 1'b0, rd_rst_busy: 1'b0};
        end else begin
            if (grant_fire) rr_ptr_q <= sel_next[PTR_W-1:0];
            wr_pend_q   <= grant_fire;
            rd_en_reg   <= fifo_request_signals_in.rd_en;
            out_valid_q <= pop;
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_fire, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            status_q <= '{full: buf_full, empty: buf_empty,
                          prog_full: (count_q >= CNT_W'(PROG_THRESH)), valid: !buf_empty,
                          wr_rst_busy: 1'b0, rd_rst_busy: 1'b0};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (grant_fire) wr_data_q <= grant_data;
        if (wr_fire)    mem[wr_ptr_q] <= wr_data_q;
        if (pop)        out_payload_q <= mem[rd_ptr_q];
    end

    always @(posedge ap_clk) begin
        if (!areset_control) assert (!(wr_pend_q && buf_full));
    end

`ifdef ARBITER_N_TO_1_STATS_EN
    logic [N-1:0][31:0] grant_cnt_q;

    always_ff @(posedge ap_clk) begin
        if (areset_control) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant_out[i] && grant_cnt_q[i] != 32'hFFFF_FFFF) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign grant_count_out = grant_cnt_q;
`endif

    assign fifo_request_signals_out = status_q;
    assign request_out              = '{valid: out_valid_q, payload: out_payload_q};
    assign fifo_setup_signal        = setup_q;
endmodule

// File: tb/tb_arbiter_n_to_1_request_rr.sv
// Directed bench for arbiter_n_to_1_request_rr: a 2-requestor and a 4-requestor instance.
module tb_arbiter_n_to_1_request_rr;
    import arbiter_n_to_1_request_rr_pkg::*;

    logic ap_clk = 1'b0;
    logic areset = 1'b1;
    always #5 ap_clk = ~ap_clk;

    MemoryPacket [1:0]     req_a;
    MemoryPacket [3:0]     req_b;
    logic [1:0]            grant_a;
    logic [3:0]            grant_b;
    FIFOStateSignalsInput  fin_a, fin_b;
    FIFOStateSignalsOutput fout_a, fout_b;
    MemoryPacket           out_a, out_b;
    logic                  setup_a, setup_b;
`ifdef ARBITER_N_TO_1_STATS_EN
    logic [1:0][31:0]      gcnt_a;
    logic [3:0][31:0]      gcnt_b;
`endif

    arbiter_n_to_1_request_rr #(
        .NUM_MEMORY_REQUESTOR(2), .FIFO_DEPTH(32), .PROG_THRESH(16)
    ) dut_a (
        .ap_clk(ap_clk), .areset(areset), .request_in(req_a), .grant_out(grant_a),
        .fifo_request_signals_in(fin_a), .fifo_request_signals_out(fout_a),
        .request_out(out_a), .fifo_setup_signal(setup_a)
`ifdef ARBITER_N_TO_1_STATS_EN
        , .grant_count_out(gcnt_a)
`endif
    );

    arbiter_n_to_1_request_rr #(
        .NUM_MEMORY_REQUESTOR(4), .FIFO_DEPTH(32), .PROG_THRESH(16)
    ) dut_b (
        .ap_clk(ap_clk), .areset(areset), .request_in(req_b), .grant_out(grant_b),
        .fifo_request_signals_in(fin_b), .fifo_request_signals_out(fout_b),
        .request_out(out_b), .fifo_setup_signal(setup_b)
`ifdef ARBITER_N_TO_1_STATS_EN
        , .grant_count_out(gcnt_b)
`endif
    );

    // Requestor FIFO model: head/tail indexed storage per requestor.
    logic [31:0] rq_mem [4][64];
    int          rq_head [4];
    int          rq_tail [4];
    int          grant_log [$];
    int          grant_cyc [$];
    logic [31:0] out_log [$];
    int          out_cyc [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_multi = 0;
    int          max_cnt = 0;
    int          cyc = 0;
    bit          sel_b = 1'b0;

    int          exp_fair_g [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] exp_fair_o [8] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1,
                                    32'hA2, 32'hB2, 32'hA3, 32'hB3};
    int          exp_skip_g [4] = '{1, 3, 1, 3};
    logic [31:0] exp_skip_o [4] = '{32'hC0, 32'hD0, 32'hC1, 32'hD1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int glog(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic logic [31:0] olog(input int i);
        return (i < out_log.size()) ? out_log[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic push(input int r, input logic [31:0] v);
        rq_mem[r][rq_tail[r]] = v;
        rq_tail[r]++;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        grant_log.delete();
        grant_cyc.delete();
        out_log.delete();
        out_cyc.delete();
        n_multi = 0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            req_a[i].valid   = !sel_b && (rq_head[i] < rq_tail[i]);
            req_a[i].payload = rq_mem[i][rq_head[i]];
        end
        for (int i = 0; i < 4; i++) begin
            req_b[i].valid   = sel_b && (rq_head[i] < rq_tail[i]);
            req_b[i].payload = rq_mem[i][rq_head[i]];
        end
    endtask

    // Sample at negedge, pop granted requestor just after the posedge.
    task automatic run(input int ncyc);
        drive_reqs();
        repeat (ncyc) begin
            logic [3:0] g;
            int         gi;
            @(negedge ap_clk);
            g  = sel_b ? grant_b : {2'b00, grant_a};
            gi = -1;
            if (g != 4'b0) begin
                if (!$onehot(g)) n_multi++;
                for (int k = 0; k < 4; k++) if (g[k]) gi = k;
                grant_log.push_back(gi);
                grant_cyc.push_back(cyc);
            end
            if (sel_b ? out_b.valid : out_a.valid) begin
                out_log.push_back(sel_b ? out_b.payload : out_a.payload);
                out_cyc.push_back(cyc);
            end
            if (int'(dut_a.count_q) > max_cnt) max_cnt = int'(dut_a.count_q);
            @(posedge ap_clk);
            #1;
            if (gi >= 0) rq_head[gi]++;
            drive_reqs();
            cyc++;
        end
    endtask

    initial begin
        fin_a.rd_en = 1'b0;
        fin_b.rd_en = 1'b0;
        reset_model();
        for (int r = 0; r < 4; r++) for (int k = 0; k < 64; k++) rq_mem[r][k] = '0;
        drive_reqs();

        // Reset values
        areset = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_grant", grant_a, 0);
        check("rst_out_valid", out_a.valid, 0);
        check("rst_empty", fout_a.empty, 1);
        check("rst_full", fout_a.full, 0);
        check("rst_prog_full", fout_a.prog_full, 0);
        check("rst_valid", fout_a.valid, 0);
        check("rst_busy", {fout_a.wr_rst_busy, fout_a.rd_rst_busy}, 0);
        check("rst_setup", setup_a, 1);
        areset = 1'b0;
        @(posedge ap_clk);
        #1;
        check("setup_release1", setup_a, 1);
        @(posedge ap_clk);
        #1;
        check("setup_release2", setup_a, 0);
        check("setup_release2_b", setup_b, 0);

        // Fairness, N=2
        fin_a.rd_en = 1'b1;
        reset_model();
        for (int k = 0; k < 4; k++) begin
            push(0, 32'hA0 + 32'(k));
            push(1, 32'hB0 + 32'(k));
        end
        run(30);
        check("fair_ngrants", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("fair_grant%0d", i), glog(i), exp_fair_g[i]);
        check("fair_nout", out_log.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("fair_out%0d", i), olog(i), exp_fair_o[i]);
        if (grant_cyc.size() == 8 && out_cyc.size() == 8) begin
            check("fair_latency", out_cyc[0] - grant_cyc[0], 3);
            check("fair_back_to_back", grant_cyc[7] - grant_cyc[0], 7);
        end else begin
            check("fair_log_sizes", {grant_cyc.size(), out_cyc.size()}, {32'd8, 32'd8});
        end
        check("fair_onehot", n_multi, 0);

        // Backpressure
        fin_a.rd_en = 1'b0;
        reset_model();
        max_cnt = 0;
        for (int k = 0; k < 20; k++) push(0, 32'h100 + 32'(k));
        run(40);
        check("bp_ngrants_stall", grant_log.size(), 16);
        check("bp_prog_full", fout_a.prog_full, 1);
        check("bp_count", dut_a.count_q, 16);
        check("bp_no_out", out_log.size(), 0);
        fin_a.rd_en = 1'b1;
        run(60);
        check("bp_ngrants_total", grant_log.size(), 20);
        check("bp_nout", out_log.size(), 20);
        for (int i = 0; i < 20; i++) check($sformatf("bp_out%0d", i), olog(i), 32'h100 + 32'(i));
        check("bp_max_count_ok", max_cnt <= 17, 1);
        check("bp_drained_empty", fout_a.empty, 1);

        // Skip idle requestors, N=4
        sel_b = 1'b1;
        fin_b.rd_en = 1'b1;
        reset_model();
        push(1, 32'hC0);
        push(1, 32'hC1);
        push(3, 32'hD0);
        push(3, 32'hD1);
        run(20);
        check("skip_ngrants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("skip_grant%0d", i), glog(i), exp_skip_g[i]);
        for (int i = 0; i < 4; i++) check($sformatf("skip_out%0d", i), olog(i), exp_skip_o[i]);

        // Reset with packets buffered
        sel_b = 1'b0;
        fin_a.rd_en = 1'b0;
        reset_model();
        for (int k = 0; k < 5; k++) push(0, 32'h200 + 32'(k));
        run(12);
        check("midrst_ngrants", grant_log.size(), 5);
        check("midrst_count_before", dut_a.count_q, 5);
        areset = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        areset = 1'b0;
        fin_a.rd_en = 1'b1;
        reset_model();
        run(10);
        check("midrst_no_stale_out", out_log.size(), 0);
        check("midrst_count_after", dut_a.count_q, 0);
        check("midrst_empty", fout_a.empty, 1);

`ifdef ARBITER_N_TO_1_STATS_EN
        reset_model();
        for (int k = 0; k < 10; k++) push(1, 32'h300 + 32'(k));
        run(30);
        check("stats_req1", gcnt_a[1], 10);
        check("stats_req0", gcnt_a[0], 0);
        areset = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("stats_rst_req1", gcnt_a[1], 0);
        check("stats_rst_req0", gcnt_a[0], 0);
        areset = 1'b0;
        repeat (2) @(posedge ap_clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
